seq_div_8by4: RTL and testbench

Sequential restoring divider, the inverse operation of the team's 4x4 array multiplier. It divides a 2W-bit dividend (multiplier product width) by a W-bit divisor, producing one quotient bit per clock. It reuses the half/full-adder style datapath (one subtract-and-restore step per cycle) behind a start/done handshake, so it can sit beside the multiplier in the arithmetic block.

---
 rtl/seq_div_8by4_pkg.sv | 19 +
 rtl/seq_div_8by4_div_step.sv | 35 +++
 rtl/seq_div_8by4.sv | 113 +++++++++++
 tb/tb_seq_div_8by4.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_8by4_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package seq_div_8by4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int WN_DEF    = 8;
    localparam int WD_DEF    = 4;
    localparam int CNT_W_DEF = $clog2(WN_DEF + 1);

    // Step counter must hold the value WN itself, hence WN+1 codes.
    function automatic int cnt_w(input int wn);
        return $clog2(wn + 1);
    endfunction

endpackage

// File: rtl/seq_div_8by4_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor with a ripple of full-adder cells, restore when the borrow fires.
module seq_div_8by4_div_step #(
    parameter int WD = 4
) (
    input  logic [WD-1:0] i_p,
    input  logic          i_bit,
    input  logic [WD-1:0] i_d,
    output logic [WD-1:0] o_p,
    output logic          o_q
);

    logic [WD:0]   w_a;
    logic [WD:0]   w_b;
    logic [WD-1:0] w_diff;
    logic [WD+1:0] w_c;

    // The partial remainder is always below D after a step, so only its low
    // WD bits are stored; the shifted value still needs WD+1 bits.
    assign w_a    = {i_p, i_bit};
    assign w_b    = ~{1'b0, i_d};
    assign w_c[0] = 1'b1;

    for (genvar i = 0; i <= WD; i++) begin : g_fa
        assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
        if (i < WD) begin : g_sum
            assign w_diff[i] = w_a[i] ^ w_b[i] ^ w_c[i];
        end
    end

    // Carry out of a + ~b + 1 means no borrow, i.e. the trial result is >= 0.
    assign o_q = w_c[WD+1];
    assign o_p = o_q ? w_diff : w_a[WD-1:0];

endmodule

// File: rtl/seq_div_8by4.sv
// Sequential restoring divider: WN-bit dividend by WD-bit divisor, one
// quotient bit per clock, start/done handshake with divide-by-zero flag.
module seq_div_8by4
    import seq_div_8by4_pkg::*;
#(
    parameter int WN = WN_DEF,
    parameter int WD = WD_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [WN-1:0] i_n,
    input  logic [WD-1:0] i_d,
    output logic          o_busy,
    output logic          o_done,
    output logic [WN-1:0] o_q,
    output logic [WD-1:0] o_r,
    output logic          o_dz
);

    localparam int CW = cnt_w(WN);

    state_t        r_state;
    state_t        w_next;
    logic [WN-1:0] r_ns;
    logic [WD-1:0] r_p;
    logic [WD-1:0] r_d;
    logic [CW-1:0] r_cnt;
    logic [WN-1:0] r_q;
    logic [WD-1:0] r_r;
    logic          r_dz;

    logic [WD-1:0] w_p_next;
    logic          w_qbit;
    logic          w_accept;
    logic          w_last;

    seq_div_8by4_div_step #(.WD(WD)) u_step (
        .i_p   (r_p),
        .i_bit (r_ns[WN-1]),
        .i_d   (r_d),
        .o_p   (w_p_next),
        .o_q   (w_qbit)
    );

    assign w_accept = i_start && (r_state != CALC);
    assign w_last   = (r_state == CALC) && (r_cnt == CW'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, FIN: begin
                if (i_start) w_next = (i_d != '0) ? CALC : FIN;
                else         w_next = IDLE;
            end
            CALC:    if (w_last) w_next = FIN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            CALC:    o_busy = 1'b1;
            FIN:     o_done = 1'b1;
            default: ;
        endcase
    end

    // Dividend shift register doubles as the quotient register: each step
    // drops a dividend bit off the top and pushes a quotient bit in below.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ns  <= '0;
            r_p   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_ns  <= i_n;
            r_p   <= '0;
            r_d   <= i_d;
            r_cnt <= CW'(WN);
            if (i_d == '0) begin
                r_q  <= '1;
                r_r  <= i_n[WD-1:0];
                r_dz <= 1'b1;
            end
        end else if (r_state == CALC) begin
            r_ns  <= {r_ns[WN-2:0], w_qbit};
            r_p   <= w_p_next;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_q  <= {r_ns[WN-2:0], w_qbit};
                r_r  <= w_p_next;
                r_dz <= 1'b0;
            end
        end
    end

    assign o_q  = r_q;
    assign o_r  = r_r;
    assign o_dz = r_dz;

endmodule

// File: tb/tb_seq_div_8by4.sv
// Bench for seq_div_8by4: per-cycle reference model on arithmetic division,
// directed literal cases, async reset, back-to-back, sweep and random traffic.
module tb_seq_div_8by4;

    localparam int WN = 8;
    localparam int WD = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [WN-1:0] n_in;
    logic [WD-1:0] d_in;
    logic          busy;
    logic          done;
    logic [WN-1:0] q_out;
    logic [WD-1:0] r_out;
    logic          dz;

    int n_pass  = 0;
    int n_total = 0;

    seq_div_8by4 #(.WN(WN), .WD(WD)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_n     (n_in),
        .i_d     (d_in),
        .o_busy  (busy),
        .o_done  (done),
        .o_q     (q_out),
        .o_r     (r_out),
        .o_dz    (dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a division in flight completes WN edges after capture
    // with quotient/remainder from plain integer arithmetic; D=0 completes on
    // the capture edge itself. Inputs are stable at the falling edge, so the
    // model compares first, then advances for the upcoming rising edge.
    initial begin
        int unsigned m_rem;
        int          m_q, m_r, m_dz, m_done, pq, pr;
        m_rem = 0; m_q = 0; m_r = 0; m_dz = 0; m_done = 0; pq = 0; pr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_rem = 0; m_q = 0; m_r = 0; m_dz = 0; m_done = 0;
            end
            chk("model_busy", int'(busy),  int'(m_rem > 0));
            chk("model_done", int'(done),  m_done);
            chk("model_q",    int'(q_out), m_q);
            chk("model_r",    int'(r_out), m_r);
            chk("model_dz",   int'(dz),    m_dz);
            if (!rst) begin
                m_done = 0;
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_q = pq; m_r = pr; m_dz = 0; m_done = 1;
                    end
                end else if (start) begin
                    if (d_in == 0) begin
                        m_q = 255; m_r = int'(n_in) % 16; m_dz = 1; m_done = 1;
                    end else begin
                        pq = int'(n_in) / int'(d_in);
                        pr = int'(n_in) % int'(d_in);
                        m_rem = WN;
                    end
                end
            end
        end
    end

    // lat counts rising edges from driving START to seeing DONE.
    task automatic run_div(input int nn, input int dd,
                           output int q, output int r, output int z,
                           output int lat, output int bcnt);
        @(posedge clk); #1;
        start = 1'b1; n_in = 8'(nn); d_in = 4'(dd);
        @(posedge clk); #1;
        start = 1'b0;
        lat  = 1;
        bcnt = int'(busy);
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            bcnt += int'(busy);
        end
        if (!done) chk("done_timeout", 0, 1);
        q = int'(q_out); r = int'(r_out); z = int'(dz);
    endtask

    task automatic hold_chk(input int q, input int r);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", int'(q_out), q);
        chk("hold_r", int'(r_out), r);
    endtask

    int q, r, z, lat, bc, guard;
    int dir_n[3] = '{255, 7, 225};
    int dir_d[3] = '{1, 9, 15};
    int dir_q[3] = '{255, 0, 15};
    int dir_r[3] = '{0, 7, 0};

    initial begin
        rst = 1'b1; start = 1'b0; n_in = '0; d_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q_out), 0);
        chk("rst_r", int'(r_out), 0);
        chk("rst_dz", int'(dz), 0);
        rst = 1'b0;

        run_div(200, 13, q, r, z, lat, bc);
        chk("200/13_lat", lat, 9);
        chk("200/13_busy_cycles", bc, 8);
        chk("200/13_q", q, 15);
        chk("200/13_r", r, 5);
        chk("200/13_dz", z, 0);
        hold_chk(15, 5);

        for (int i = 0; i < 3; i++) begin
            run_div(dir_n[i], dir_d[i], q, r, z, lat, bc);
            chk("dir_q", q, dir_q[i]);
            chk("dir_r", r, dir_r[i]);
            hold_chk(dir_q[i], dir_r[i]);
        end

        run_div(100, 0, q, r, z, lat, bc);
        chk("dz_lat", lat, 1);
        chk("dz_flag", z, 1);
        chk("dz_q", q, 255);
        chk("dz_r", r, 4);
        run_div(100, 10, q, r, z, lat, bc);
        chk("after_dz_flag", z, 0);
        chk("after_dz_q", q, 10);
        chk("after_dz_r", r, 0);

        // Back-to-back: START held, second operands presented in FIN cycle.
        @(posedge clk); #1;
        start = 1'b1; n_in = 8'd200; d_in = 4'd13;
        guard = 0;
        do begin @(posedge clk); #1; guard++; end while (!done && guard < 30);
        chk("b2b_first_done", int'(done), 1);
        chk("b2b_first_q", int'(q_out), 15);
        n_in = 8'd100; d_in = 4'd10;
        @(posedge clk); #1;
        chk("b2b_no_idle", int'(busy), 1);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; n_in = 8'd3; d_in = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!done && guard < 30) begin @(posedge clk); #1; guard++; end
        chk("b2b_second_done", int'(done), 1);
        chk("b2b_second_q", int'(q_out), 10);
        chk("b2b_second_r", int'(r_out), 0);

        // Asynchronous reset in the middle of a division.
        @(posedge clk); #1;
        start = 1'b1; n_in = 8'd200; d_in = 4'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_q", int'(q_out), 0);
        chk("arst_r", int'(r_out), 0);
        chk("arst_dz", int'(dz), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bc = 0;
        repeat (12) begin @(posedge clk); #1; bc += int'(done); end
        chk("arst_no_done", bc, 0);
        run_div(200, 13, q, r, z, lat, bc);
        chk("post_rst_q", q, 15);
        chk("post_rst_r", r, 5);

        for (int nn = 0; nn < 256; nn++) begin
            for (int dd = 1; dd < 16; dd++) begin
                run_div(nn, dd, q, r, z, lat, bc);
                chk("sweep_identity", q * dd + r, nn);
                chk("sweep_r_lt_d", int'(r < dd), 1);
            end
        end

        // Random traffic, including START during CALC and D=0.
        repeat (400) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            n_in  = 8'($urandom_range(0, 255));
            d_in  = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
